if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline; the producer end of the IF→ID handshake.
- Holds the PC and issues reads to a synchronous instruction SRAM with a fixed 1-cycle read latency.
- Delivers {inst, pc} to ID and applies branch redirects that come back from ID.
- Holds the fetched instruction in a skid buffer while ID stalls, so SRAM read data is never lost.

Parameters:
RESET_PC, 32'h1c000000, address of the first instruction fetched after reset.

Ports:
clk  in  1  clock; all state on the rising edge.
resetn  in  1  asynchronous active-low reset.
id_allowin  in  1  ID can accept an instruction this cycle.
if_to_id_valid  out  1  if_reg holds a valid instruction for ID.
if_reg  out  64  {inst[63:32], pc[31:0]}.
branch_reg  in  33  {br_taken[32], br_target[31:0]} from ID.
br_taken_cancel  in  1  ID commits a taken branch this cycle; flush and redirect.
inst_sram_en  out  1  read enable.
inst_sram_we  out  4  tied to 4'h0.
inst_sram_addr  out  32  fetch address (nextpc).
inst_sram_wdata  out  32  tied to 32'h0.
inst_sram_rdata  in  32  read data, valid the cycle after en.

Behaviour:
- Reset (async, resetn=0):
  - pc register = RESET_PC-4; if_valid=0; buf_valid=0; br_pending=0; rdata_fresh=0.
  - Outputs during reset: if_to_id_valid=0, inst_sram_en=0.
- Handshake signals:
  - if_ready_go=1.
  - if_allowin = !if_valid | (id_allowin & if_ready_go).
  - if_to_id_valid = if_valid & ~br_taken_cancel.
  - A transfer happens when if_to_id_valid & id_allowin.
- Redirect: redirect = br_taken_cancel & branch_reg[32]. br_taken without br_taken_cancel never redirects, because rj may be stale during a hazard.
- nextpc priority: redirect ? br_target : br_pending ? pending_target : pc+4. All arithmetic is 32-bit modulo; 32'hfffffffc+4 wraps to 0.
- inst_sram_en = resetn_released & if_allowin, where resetn_released is a flop set on the first clk after resetn deasserts; inst_sram_addr = nextpc.
- Fetch cycle (en=1): pc<=nextpc, if_valid<=1, rdata_fresh<=1, br_pending<=0, buf_valid<=0.
- Redirect while if_allowin=0: no fetch; if_valid<=0 (wrong-path instruction killed); br_pending<=1; pending_target<=br_target. The next cycle if_allowin=1 and the fetch goes to pending_target.
- Redirect while if_allowin=1: fetch br_target directly in that same cycle. The instruction leaving IF is killed by ID.
- Skid buffer:
  - If rdata_fresh & if_valid & no transfer & ~redirect: inst_buf<=inst_sram_rdata, buf_valid<=1.
  - rdata_fresh clears whenever no fetch is issued.
  - if_reg inst = buf_valid ? inst_buf : inst_sram_rdata.
  - buf_valid clears on transfer, redirect, or a new fetch.
- Throughput: one instruction per cycle when there is no stall. Redirect penalty: 1 bubble when if_allowin=1, 2 bubbles when a pending redirect is recorded.
- Simultaneous redirect and transfer: redirect wins; the IF instruction is dropped (if_to_id_valid is forced 0).
- Reset asserted mid-stall or with a pending redirect: all state clears; the fetch restarts at RESET_PC.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds outputs fetch_cnt[31:0] (+1 per SRAM read) and flush_cnt[31:0] (+1 per redirect). Both are 32-bit wrapping counters, async-cleared to 0 by resetn.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, id_allowin=1: addr sequence 1c000000, 1c000004, 1c000008; if_to_id_valid goes high the cycle after the first en; if_reg pc=1c000000.
- id_allowin=0 for 3 cycles with if_valid=1: en=0 throughout; if_reg holds {inst@1c000004, 1c000004} stable even after SRAM rdata is driven to garbage; that instruction is delivered once when id_allowin returns to 1.
- br_taken_cancel=1, branch_reg={1, 1c000100}, id_allowin=1: same-cycle addr=1c000100, if_to_id_valid=0 that cycle, next if_reg pc=1c000100.
- br_taken_cancel=1 with id_allowin=0 (target 1c000200): no fetch; if_valid drops; next cycle addr=1c000200; br_pending then clears.
- branch_reg[32]=1 with br_taken_cancel=0 (hazard): no redirect; sequential pc+4 continues.
- resetn pulsed low while br_pending=1: outputs go to their reset values asynchronously; the first fetch after release is at 1c000000; with IF_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage LoongArch pipeline.
//
// Holds the PC and reads a synchronous instruction SRAM with a 1-cycle
// latency. It hands {inst, pc} to ID over a valid/allowin handshake and
// applies taken-branch redirects that come back from ID. A one-entry skid
// buffer keeps the returned SRAM word while ID stalls, so the word is not lost
// when the SRAM read data later changes.
//
// Ports:
//   clk, resetn         rising-edge clock, asynchronous active-low reset
//   id_allowin          ID can accept an instruction this cycle
//   if_to_id_valid      if_reg carries a valid instruction for ID
//   if_reg[63:0]        {inst[63:32], pc[31:0]}
//   branch_reg[32:0]    {br_taken, br_target} from ID
//   br_taken_cancel     ID commits a taken branch: flush IF and redirect
//   inst_sram_*         synchronous SRAM read port (we/wdata tied off)
//   fetch_cnt/flush_cnt perf counters (only with IF_PERF_CNT_EN defined)
//
// Optional feature: define IF_PERF_CNT_EN to add fetch_cnt and flush_cnt.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [63:0] if_reg,
  input  logic [32:0] branch_reg,
  input  logic        br_taken_cancel,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic IF_READY_GO = 1'b1;

  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] pending_target_q, pending_target_d;
  logic        rdata_fresh_q, rdata_fresh_d;
  logic        resetn_released_q;

  logic        if_allowin;
  logic        transfer;
  logic        redirect;
  logic        fetch;
  logic [31:0] br_target;
  logic [31:0] nextpc;

  assign br_target  = branch_reg[31:0];
  assign if_allowin = !if_valid_q | (id_allowin & IF_READY_GO);
  // br_taken alone is not trusted: rj may be stale during a hazard, so only a
  // committed cancel from ID redirects.
  assign redirect   = br_taken_cancel & branch_reg[32];
  assign transfer   = if_to_id_valid & id_allowin;
  // Holding off the first read until a clock after reset release keeps the
  // SRAM enable away from the asynchronous deassertion edge.
  assign fetch      = resetn_released_q & if_allowin;

  assign nextpc = redirect     ? br_target        :
                  br_pending_q ? pending_target_q :
                                 pc_q + 32'd4;

  assign if_to_id_valid  = if_valid_q & ~br_taken_cancel;
  assign if_reg          = {(buf_valid_q ? inst_buf_q : inst_sram_rdata), pc_q};
  assign inst_sram_en    = fetch;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // NOTE: every *_d gets a default first so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    pc_d             = pc_q;
    if_valid_d       = if_valid_q;
    buf_valid_d      = buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_pending_d     = br_pending_q;
    pending_target_d = pending_target_q;
    rdata_fresh_d    = 1'b0;

    if (fetch) begin
      pc_d          = nextpc;
      if_valid_d    = 1'b1;
      rdata_fresh_d = 1'b1;
      br_pending_d  = 1'b0;
      buf_valid_d   = 1'b0;
    end else if (redirect) begin
      // IF is full and stalled: kill the wrong-path instruction and remember
      // where to go once a fetch slot opens.
      if_valid_d       = 1'b0;
      br_pending_d     = 1'b1;
      pending_target_d = br_target;
      buf_valid_d      = 1'b0;
    end else if (transfer) begin
      buf_valid_d = 1'b0;
    end else if (rdata_fresh_q & if_valid_q) begin
      // Last cycle's read data is only on the SRAM port now; keep it.
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q              <= RESET_PC - 32'd4;
      if_valid_q        <= 1'b0;
      buf_valid_q       <= 1'b0;
      inst_buf_q        <= 32'h0;
      br_pending_q      <= 1'b0;
      pending_target_q  <= 32'h0;
      rdata_fresh_q     <= 1'b0;
      resetn_released_q <= 1'b0;
    end else begin
      pc_q              <= pc_d;
      if_valid_q        <= if_valid_d;
      buf_valid_q       <= buf_valid_d;
      inst_buf_q        <= inst_buf_d;
      br_pending_q      <= br_pending_d;
      pending_target_q  <= pending_target_d;
      rdata_fresh_q     <= rdata_fresh_d;
      resetn_released_q <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (fetch)    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A directed vector table walks the fetch scenarios (reset release, ID stall
// with a garbage SRAM port, both redirect flavours, stale-branch hazard,
// reset during a pending redirect, address wrap), followed by random traffic.
// The reference model tracks the architectural view only: which PC IF holds,
// whether it is valid, and an outstanding redirect target. The instruction it
// expects is always the memory word at the held PC, whatever buffering the
// design uses to deliver it.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_reg;
  logic [32:0] branch_reg;
  logic        br_taken_cancel;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .id_allowin      (id_allowin),
    .if_to_id_valid  (if_to_id_valid),
    .if_reg          (if_reg),
    .branch_reg      (branch_reg),
    .br_taken_cancel (br_taken_cancel),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Contents of the instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h13572468;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_ptgt;
  logic        m_rel;
  logic [31:0] m_fcnt;
  logic [31:0] m_xcnt;
  logic        prev_en;
  logic [31:0] prev_addr;
  // per-cycle decisions made in apply() and committed in finish_cycle()
  logic        m_en;
  logic        m_redirect;
  logic [31:0] m_next;
  logic [31:0] m_tgt;

  task automatic model_reset();
    m_pc    = RESET_PC - 32'd4;
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ptgt  = 32'h0;
    m_rel   = 1'b0;
    m_fcnt  = 32'h0;
    m_xcnt  = 32'h0;
    prev_en = 1'b0;
    prev_addr = 32'h0;
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks outputs.
  task automatic apply(input logic alw, input logic btc, input logic [32:0] br);
    id_allowin      = alw;
    br_taken_cancel = btc;
    branch_reg      = br;
    // The SRAM returns data only the cycle after a read; otherwise garbage.
    inst_sram_rdata = prev_en ? mem_word(prev_addr) : $urandom();
    #2;
    m_redirect = btc & br[32];
    m_tgt      = br[31:0];
    m_en       = m_rel & (!m_valid | alw);
    if (m_redirect)  m_next = m_tgt;
    else if (m_pend) m_next = m_ptgt;
    else             m_next = m_pc + 32'd4;

    check("sram_en", 64'(inst_sram_en), 64'(m_en));
    check("sram_addr", 64'(inst_sram_addr), 64'(m_next));
    check("if_to_id_valid", 64'(if_to_id_valid), 64'(m_valid & ~btc));
    if (m_valid) check("if_reg", if_reg, {mem_word(m_pc), m_pc});
    check("sram_we", 64'(inst_sram_we), 64'h0);
    check("sram_wdata", 64'(inst_sram_wdata), 64'h0);
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", 64'(fetch_cnt), 64'(m_fcnt));
    check("flush_cnt", 64'(flush_cnt), 64'(m_xcnt));
`endif
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
    prev_en   = m_en;
    prev_addr = m_next;
    if (m_en)       m_fcnt = m_fcnt + 32'd1;
    if (m_redirect) m_xcnt = m_xcnt + 32'd1;
    if (m_en) begin
      m_pc    = m_next;
      m_valid = 1'b1;
      m_pend  = 1'b0;
    end else if (m_redirect) begin
      m_valid = 1'b0;
      m_pend  = 1'b1;
      m_ptgt  = m_tgt;
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks the asynchronous
  // response, then releases and leaves the design one edge past release.
  task automatic pulse_reset();
    id_allowin      = 1'b1;
    br_taken_cancel = 1'b0;
    branch_reg      = 33'h0;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_sram_en", 64'(inst_sram_en), 64'h0);
    check("rst_if_to_id_valid", 64'(if_to_id_valid), 64'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_fetch_cnt", 64'(fetch_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    m_rel = 1'b1;
  endtask

  typedef struct {
    logic        do_reset;
    logic        alw;
    logic        btc;
    logic [32:0] br;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_tv;
    logic        chk_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // reset release, sequential fetch
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000004, 1'b1, 1'b1, 32'h1c000000};
    // ID stalls 3 cycles: no fetch, instruction held across garbage rdata
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 33'h0, 1'b0, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 33'h0, 1'b0, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 33'h0, 1'b0, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000008, 1'b1, 1'b1, 32'h1c000004};
    // redirect with allowin: same-cycle fetch of the target
    vecs[6]  = '{1'b0, 1'b1, 1'b1, {1'b1, 32'h1c000100}, 1'b1, 32'h1c000100, 1'b0, 1'b1, 32'h1c000008};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000104, 1'b1, 1'b1, 32'h1c000100};
    // redirect while stalled: recorded, fetched next cycle
    vecs[8]  = '{1'b0, 1'b0, 1'b1, {1'b1, 32'h1c000200}, 1'b0, 32'h1c000200, 1'b0, 1'b1, 32'h1c000104};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 33'h0, 1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000204, 1'b1, 1'b1, 32'h1c000200};
    // br_taken without cancel: ignored
    vecs[11] = '{1'b0, 1'b1, 1'b0, {1'b1, 32'h1c000300}, 1'b1, 32'h1c000208, 1'b1, 1'b1, 32'h1c000204};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c00020c, 1'b1, 1'b1, 32'h1c000208};
    // leave a redirect pending, then reset clears it
    vecs[13] = '{1'b0, 1'b0, 1'b1, {1'b1, 32'h1c000400}, 1'b0, 32'h1c000400, 1'b0, 1'b1, 32'h1c00020c};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 33'h0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0};
    // address wrap
    vecs[15] = '{1'b0, 1'b1, 1'b1, {1'b1, 32'hfffffffc}, 1'b1, 32'hfffffffc, 1'b0, 1'b1, 32'h1c000000};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h00000000, 1'b1, 1'b1, 32'hfffffffc};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 33'h0, 1'b1, 32'h00000004, 1'b1, 1'b1, 32'h00000000};

    resetn          = 1'b0;
    id_allowin      = 1'b1;
    br_taken_cancel = 1'b0;
    branch_reg      = 33'h0;
    inst_sram_rdata = 32'h0;
    model_reset();
    @(posedge clk);
    #1;
    pulse_reset();

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].do_reset) pulse_reset();
      apply(vecs[i].alw, vecs[i].btc, vecs[i].br);
      check($sformatf("vec%0d_en", i), 64'(inst_sram_en), 64'(vecs[i].exp_en));
      check($sformatf("vec%0d_addr", i), 64'(inst_sram_addr), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_valid", i), 64'(if_to_id_valid), 64'(vecs[i].exp_tv));
      if (vecs[i].chk_pc)
        check($sformatf("vec%0d_if_reg", i), if_reg,
              {mem_word(vecs[i].exp_pc), vecs[i].exp_pc});
      finish_cycle();
    end

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 800; n++) begin
      logic        alw;
      logic        btc;
      logic [32:0] br;
      if ($urandom_range(0, 149) == 0) pulse_reset();
      alw = ($urandom_range(0, 9) < 7);
      btc = ($urandom_range(0, 5) == 0);
      br  = {1'($urandom_range(0, 1)), $urandom() & 32'hfffffffc};
      if ($urandom_range(0, 9) == 0) br[31:0] = 32'hfffffff8;
      apply(alw, btc, br);
      finish_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
